// File: rtl/capture_pkg.sv
// Shared types and helpers for the multi-bank sample capture controller.
package capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_DONE    = 2'd2
  } cap_state_e;

  localparam int WR_COUNT_W = 32;

  // Sample counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
    return (&v) ? v : v + WR_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// One capture bank: single write port, single registered read port.
// A read and write to the same word on one edge returns the old contents.
module capture_ram #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 65536,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array and read register; the read samples the array before the write lands.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_bank_ctrl.sv
// Multi-bank sample capture: on start, fills NUM_BANKS banks of DEPTH words in
// order from signal_in, then flags done. Random-access read port for analysis.
// Optional feature: define CAPTURE_DECIM_EN to add the decim[7:0] input, which
// keeps only every (decim+1)-th valid sample during capture.
module capture_bank_ctrl
  import capture_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 65536,
  parameter  int NUM_BANKS = 3,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     signal_in,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]            decim,
`endif
  input  logic                  rd_en,
  input  logic [BANK_W-1:0]     rd_bank,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [BANK_W-1:0]     cur_bank,
  output logic [WR_COUNT_W-1:0] wr_count
);

  cap_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [BANK_W-1:0]     cur_bank_q, cur_bank_d;
  logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
  logic                  wr_en;
  logic                  keep;

  logic                  rd_valid_q;
  logic                  rd_seen_q;
  logic [BANK_W-1:0]     rd_bank_q;
  logic [DATA_W-1:0]     bank_rd [NUM_BANKS];
  logic [DATA_W-1:0]     rd_mux;

`ifdef CAPTURE_DECIM_EN
  logic [7:0]            phase_q, phase_d;
`endif

  // Next-state and write-sequencing logic for the capture FSM.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    cur_bank_d = cur_bank_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    keep       = 1'b1;
`ifdef CAPTURE_DECIM_EN
    phase_d    = phase_q;
    if (state_q == CAP_CAPTURE && sample_valid) begin
      keep    = (phase_q == 8'd0);
      phase_d = (phase_q >= decim) ? 8'd0 : phase_q + 8'd1;
    end
`endif
    case (state_q)
      CAP_IDLE, CAP_DONE: begin
        if (start && !abort) begin
          state_d    = CAP_CAPTURE;
          wr_addr_d  = '0;
          cur_bank_d = '0;
          wr_count_d = '0;
`ifdef CAPTURE_DECIM_EN
          phase_d    = 8'd0;
`endif
        end
      end
      CAP_CAPTURE: begin
        if (sample_valid && keep) begin
          wr_en      = 1'b1;
          wr_count_d = sat_inc(wr_count_q);
          wr_addr_d  = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
            // Last bank full: stop and leave cur_bank pointing at it.
            if (cur_bank_q == BANK_W'(NUM_BANKS - 1)) state_d = CAP_DONE;
            else                                     cur_bank_d = cur_bank_q + BANK_W'(1);
          end
        end
      end
      default: state_d = CAP_IDLE;
    endcase
    // Abort overrides any start; counters are left intact for inspection.
    if (abort) begin
      state_d = CAP_IDLE;
`ifdef CAPTURE_DECIM_EN
      phase_d = 8'd0;
`endif
    end
  end

  // Capture FSM state and write-side counters.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAP_IDLE;
      wr_addr_q  <= '0;
      cur_bank_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      cur_bank_q <= cur_bank_d;
      wr_count_q <= wr_count_d;
    end
  end

`ifdef CAPTURE_DECIM_EN
  // Decimation phase: position of the current valid sample within its group.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) phase_q <= 8'd0;
    else        phase_q <= phase_d;
  end
`endif

  // Read-side control: valid flag and the bank select that steers the output mux.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_seen_q <= 1'b1;
        rd_bank_q <= rd_bank;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clock   (clock),
      .wr_en   (wr_en && (cur_bank_q == BANK_W'(b))),
      .wr_addr (wr_addr_q),
      .wr_data (signal_in),
      .rd_en   (rd_en && (rd_bank == BANK_W'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  // Output mux; a bank select beyond NUM_BANKS matches nothing and reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank_q == BANK_W'(b)) rd_mux = bank_rd[b];
    end
  end

  // Bank read registers are not reset, so hide them until the first read.
  assign rd_data  = rd_seen_q ? rd_mux : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CAP_CAPTURE);
  assign done     = (state_q == CAP_DONE);
  assign cur_bank = cur_bank_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_capture_bank_ctrl.sv
// Self-checking bench for capture_bank_ctrl (DATA_W=16, DEPTH=8, NUM_BANKS=3).
// The reference model tracks the number of samples written since start; the
// bank/word of each write and the status outputs follow from that count.
module tb_capture_bank_ctrl;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 8;
  localparam int NUM_BANKS = 3;
  localparam int TOTAL     = DEPTH * NUM_BANKS;

  logic        clock = 1'b0;
  logic        rst_n, start, abort, sample_valid, rd_en;
  logic [15:0] signal_in;
  logic [1:0]  rd_bank;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid, busy, done;
  logic [1:0]  cur_bank;
  logic [31:0] wr_count;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]  decim;
`endif

  always #5 clock = ~clock;

  capture_bank_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .sample_valid(sample_valid), .signal_in(signal_in),
`ifdef CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .cur_bank(cur_bank), .wr_count(wr_count)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model
  int          m_state;   // 0 idle, 1 capturing, 2 done
  int          m_n;       // samples written since last start
  int          m_vcnt;    // valid samples seen since last start
  int          m_decim = 0;
  logic [15:0] m_mem [NUM_BANKS][DEPTH];
  bit          m_wr  [NUM_BANKS][DEPTH];
  logic [15:0] m_rd_data;
  bit          m_rd_valid;

  function automatic logic [35:0] exp_status();
    int b = m_n / DEPTH;
    if (b > NUM_BANKS - 1) b = NUM_BANKS - 1;
    return {m_state == 1, m_state == 2, 2'(b), 32'(m_n)};
  endfunction

  // Drive one cycle (called at a falling edge), advance the model, wait for the next falling edge.
  task automatic cyc(input bit st, input bit ab, input bit sv, input int din,
                     input bit re, input int rb, input int ra);
    start = st; abort = ab; sample_valid = sv; signal_in = din[15:0];
    rd_en = re; rd_bank = rb[1:0]; rd_addr = ra[2:0];
    m_rd_valid = re;
    if (re) m_rd_data = (rb < NUM_BANKS) ? m_mem[rb][ra] : 16'd0;
    if (m_state == 1 && sv) begin
      if (m_vcnt % (m_decim + 1) == 0) begin
        m_mem[m_n / DEPTH][m_n % DEPTH] = din[15:0];
        m_wr[m_n / DEPTH][m_n % DEPTH]  = 1'b1;
        m_n++;
        if (m_n == TOTAL) m_state = 2;
      end
      m_vcnt++;
    end
    if (ab) begin
      m_state = 0; m_vcnt = 0;
    end else if (st && m_state != 1) begin
      m_state = 1; m_n = 0; m_vcnt = 0;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; sample_valid = 0; signal_in = '0;
    rd_en = 0; rd_bank = '0; rd_addr = '0;
`ifdef CAPTURE_DECIM_EN
    decim = 8'd0;
`endif
    for (int b = 0; b < NUM_BANKS; b++)
      for (int a = 0; a < DEPTH; a++) m_wr[b][a] = 1'b0;
    m_state = 0; m_n = 0; m_vcnt = 0; m_rd_data = '0; m_rd_valid = 0;
    repeat (2) @(negedge clock);
    n_total++;
    if ({busy, done, cur_bank, wr_count} !== 36'd0)
      $display("FAIL reset_status got busy=%b done=%b bank=%0d cnt=%0d want all 0", busy, done, cur_bank, wr_count);
    else n_pass++;
    n_total++;
    if ({rd_valid, rd_data} !== 17'd0)
      $display("FAIL reset_read got valid=%b data=%0d want 0/0", rd_valid, rd_data);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_ramp();
    logic [35:0] e;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) begin
      cyc(0, 0, 1, i, 0, 0, 0);
      e = exp_status();
      n_total++;
      if ({busy, done, cur_bank, wr_count} !== e)
        $display("FAIL ramp_status i=%0d got %h want %h", i, {busy, done, cur_bank, wr_count}, e);
      else n_pass++;
    end
    n_total++;
    if ({busy, done, wr_count} !== {1'b0, 1'b1, 32'd24})
      $display("FAIL ramp_done got busy=%b done=%b cnt=%0d want 0/1/24", busy, done, wr_count);
    else n_pass++;
    cyc(0, 0, 1, 999, 1, 1, 3);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b1, 16'd11})
      $display("FAIL ramp_read_b1a3 got valid=%b data=%0d want 1/11", rd_valid, rd_data);
    else n_pass++;
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b0, 16'd11})
      $display("FAIL ramp_read_hold got valid=%b data=%0d want 0/11", rd_valid, rd_data);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) begin
      cyc(0, 0, 0, 0, 1, i / DEPTH, i % DEPTH);
      n_total++;
      if (rd_data !== 16'(i))
        $display("FAIL ramp_readback word=%0d got %0d want %0d", i, rd_data, i);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int k = 0;
    logic [35:0] e;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2 * TOTAL; c++) begin
      if (c % 2 == 0) begin cyc(0, 0, 1, 300 + k, 0, 0, 0); k++; end
      else cyc(0, 0, 0, 7777, 0, 0, 0);
      e = exp_status();
      n_total++;
      if ({busy, done, cur_bank, wr_count} !== e)
        $display("FAIL stall_status c=%0d got %h want %h", c, {busy, done, cur_bank, wr_count}, e);
      else n_pass++;
    end
    n_total++;
    if ({done, wr_count} !== {1'b1, 32'd24})
      $display("FAIL stall_done got done=%b cnt=%0d want 1/24", done, wr_count);
    else n_pass++;
    for (int i = 0; i < TOTAL; i += 5) begin
      cyc(0, 0, 0, 0, 1, i / DEPTH, i % DEPTH);
      n_total++;
      if (rd_data !== 16'(300 + i))
        $display("FAIL stall_readback word=%0d got %0d want %0d", i, rd_data, 300 + i);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 600 + i, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_total++;
    if ({busy, done, cur_bank, wr_count} !== {1'b0, 1'b0, 2'd1, 32'd10})
      $display("FAIL abort_status got busy=%b done=%b bank=%0d cnt=%0d want 0/0/1/10", busy, done, cur_bank, wr_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'hBEEF, 0, 0, 0);
    n_total++;
    if ({busy, cur_bank, wr_count} !== {1'b0, 2'd1, 32'd10})
      $display("FAIL abort_idle_hold got busy=%b bank=%0d cnt=%0d want 0/1/10", busy, cur_bank, wr_count);
    else n_pass++;
    cyc(0, 0, 0, 0, 1, 1, 2);
    n_total++;
    if (rd_data !== 16'd310)
      $display("FAIL abort_no_write got %0d want 310", rd_data);
    else n_pass++;
    cyc(0, 0, 0, 0, 1, 1, 1);
    n_total++;
    if (rd_data !== 16'd609)
      $display("FAIL abort_last_write got %0d want 609", rd_data);
    else n_pass++;
  endtask

  task automatic test_start_abort();
    cyc(1, 1, 0, 0, 0, 0, 0);
    n_total++;
    if ({busy, done, wr_count} !== {1'b0, 1'b0, 32'd10})
      $display("FAIL start_abort_same got busy=%b done=%b cnt=%0d want 0/0/10", busy, done, wr_count);
    else n_pass++;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 700 + i, 0, 0, 0);
    cyc(1, 0, 1, 703, 0, 0, 0);
    n_total++;
    if ({busy, cur_bank, wr_count} !== {1'b1, 2'd0, 32'd4})
      $display("FAIL start_in_capture got busy=%b bank=%0d cnt=%0d want 1/0/4", busy, cur_bank, wr_count);
    else n_pass++;
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_read_first();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 800, 0, 0, 0);
    cyc(0, 0, 1, 801, 0, 0, 0);
    cyc(0, 0, 1, 802, 1, 0, 2);
    n_total++;
    if (rd_data !== 16'd702)
      $display("FAIL read_first got %0d want old 702", rd_data);
    else n_pass++;
    cyc(0, 0, 0, 0, 1, 3, 5);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b1, 16'd0})
      $display("FAIL read_oob_bank got valid=%b data=%0d want 1/0", rd_valid, rd_data);
    else n_pass++;
    cyc(0, 0, 0, 0, 1, 0, 2);
    n_total++;
    if (rd_data !== 16'd802)
      $display("FAIL read_after_write got %0d want 802", rd_data);
    else n_pass++;
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit st, ab, sv, re;
    int rb, ra;
    logic [35:0] e;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 29) == 0);
      ab = ($urandom_range(0, 79) == 0);
      sv = $urandom_range(0, 1);
      rb = $urandom_range(0, 3);
      ra = $urandom_range(0, DEPTH - 1);
      re = $urandom_range(0, 1) && (rb >= NUM_BANKS || m_wr[rb][ra]);
      cyc(st, ab, sv, $urandom_range(0, 65535), re, rb, ra);
      e = exp_status();
      n_total++;
      if ({busy, done, cur_bank, wr_count} !== e)
        $display("FAIL rand_status c=%0d got %h want %h", c, {busy, done, cur_bank, wr_count}, e);
      else n_pass++;
      n_total++;
      if ({rd_valid, rd_data} !== {m_rd_valid, m_rd_data})
        $display("FAIL rand_read c=%0d got %b/%h want %b/%h", c, rd_valid, rd_data, m_rd_valid, m_rd_data);
      else n_pass++;
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

`ifdef CAPTURE_DECIM_EN
  task automatic test_decim();
    decim = 8'd2; m_decim = 2;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3 * TOTAL; i++) cyc(0, 0, 1, i, 0, 0, 0);
    n_total++;
    if ({done, wr_count} !== {1'b1, 32'd24})
      $display("FAIL decim_done got done=%b cnt=%0d want 1/24", done, wr_count);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      cyc(0, 0, 0, 0, 1, 0, a);
      n_total++;
      if (rd_data !== 16'(3 * a))
        $display("FAIL decim_readback addr=%0d got %0d want %0d", a, rd_data, 3 * a);
      else n_pass++;
    end
    decim = 8'd0; m_decim = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_abort();
    test_start_abort();
    test_read_first();
`ifdef CAPTURE_DECIM_EN
    test_decim();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
